// File: rtl/clk_en_gen.sv
// Multi-channel programmable clock-enable generator: per-channel one-cycle tick
// and divided square wave, with divisor changes taking effect on period boundaries.
module clk_en_gen #(
    parameter int N_CH        = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 100,
    parameter int LOCK_CYC    = 16,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_ref,
    input  logic             rst,
    input  logic             div_wr,
    input  logic [CH_W-1:0]  div_ch,
    input  logic [DIV_W-1:0] div_val,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             sync_all,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  clk_div,
    output logic             locked
);

    localparam int               LCK_W = $clog2(LOCK_CYC + 1);
    localparam logic [DIV_W-1:0] DEF_D = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] MIN_D = DIV_W'(2);

    logic [LCK_W-1:0] r_lockCnt;
    logic             r_locked;
    logic [DIV_W-1:0] r_phase   [N_CH];
    logic [DIV_W-1:0] r_div     [N_CH];
    logic [DIV_W-1:0] r_pendVal [N_CH];
    logic [N_CH-1:0]  r_pendFlag;
    logic [N_CH-1:0]  r_active;
    logic [N_CH-1:0]  r_tick;
    logic [N_CH-1:0]  r_clkDiv;

    logic [DIV_W-1:0] w_wrVal;
    logic [DIV_W-1:0] w_nextPhase   [N_CH];
    logic [DIV_W-1:0] w_nextDiv     [N_CH];
    logic [DIV_W-1:0] w_nextPendVal [N_CH];
    logic [N_CH-1:0]  w_nextPendFlag;
    logic [N_CH-1:0]  w_run;
    logic [N_CH-1:0]  w_tick;
    logic [N_CH-1:0]  w_clkDiv;

    assign w_wrVal = (div_val < MIN_D) ? MIN_D : div_val;

    // Outputs are precomputed from the next phase/divisor so they can be registered.
    // A write landing on a boundary edge is folded in so it applies at that boundary.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_run[i]          = ch_en[i] & r_locked;
            w_nextPhase[i]    = '0;
            w_nextDiv[i]      = r_div[i];
            w_nextPendFlag[i] = r_pendFlag[i];
            w_nextPendVal[i]  = r_pendVal[i];
            if (div_wr && (div_ch == CH_W'(i))) begin
                w_nextPendFlag[i] = 1'b1;
                w_nextPendVal[i]  = w_wrVal;
            end
            if (!w_run[i] || !r_active[i] || sync_all ||
                (r_phase[i] == r_div[i] - DIV_W'(1))) begin
                w_nextPhase[i] = '0;
                if (w_nextPendFlag[i]) begin
                    w_nextDiv[i]      = w_nextPendVal[i];
                    w_nextPendFlag[i] = 1'b0;
                end
            end else begin
                w_nextPhase[i] = r_phase[i] + DIV_W'(1);
            end
            w_tick[i]   = w_run[i] && (w_nextPhase[i] == w_nextDiv[i] - DIV_W'(1));
            w_clkDiv[i] = w_run[i] && (w_nextPhase[i] < (w_nextDiv[i] >> 1));
        end
    end

    always_ff @(posedge clk_ref) begin
        if (!rst) begin
            r_lockCnt  <= '0;
            r_locked   <= 1'b0;
            r_pendFlag <= '0;
            r_active   <= '0;
            r_tick     <= '0;
            r_clkDiv   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_phase[i]   <= '0;
                r_div[i]     <= DEF_D;
                r_pendVal[i] <= DEF_D;
            end
        end else begin
            if (!r_locked) begin
                r_lockCnt <= r_lockCnt + LCK_W'(1);
                if (r_lockCnt == LCK_W'(LOCK_CYC - 1)) begin
                    r_locked <= 1'b1;
                end
            end
            r_pendFlag <= w_nextPendFlag;
            r_active   <= w_run;
            r_tick     <= w_tick;
            r_clkDiv   <= w_clkDiv;
            for (int i = 0; i < N_CH; i++) begin
                r_phase[i]   <= w_nextPhase[i];
                r_div[i]     <= w_nextDiv[i];
                r_pendVal[i] <= w_nextPendVal[i];
            end
        end
    end

    assign tick    = r_tick;
    assign clk_div = r_clkDiv;
    assign locked  = r_locked;

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen; three channels so an out-of-range channel index
// exists on the 2-bit div_ch port.
module tb_clk_en_gen;

    localparam int NCH  = 3;
    localparam int LOCK = 16;

    logic        clk_ref = 1'b0;
    logic        rst;
    logic        div_wr;
    logic [1:0]  div_ch;
    logic [15:0] div_val;
    logic [2:0]  ch_en;
    logic        sync_all;
    logic [2:0]  tick;
    logic [2:0]  clk_div;
    logic        locked;

    int nVec = 0;
    int nErr = 0;

    clk_en_gen #(.N_CH(NCH), .DIV_W(16), .DEFAULT_DIV(100), .LOCK_CYC(LOCK)) dut (
        .clk_ref (clk_ref),
        .rst     (rst),
        .div_wr  (div_wr),
        .div_ch  (div_ch),
        .div_val (div_val),
        .ch_en   (ch_en),
        .sync_all(sync_all),
        .tick    (tick),
        .clk_div (clk_div),
        .locked  (locked)
    );

    always #5 clk_ref = ~clk_ref;

    // Advance n rising edges and land 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_ref);
        #1;
    endtask

    function automatic logic expTick(input int ph, input int d);
        return ph == d - 1;
    endfunction

    function automatic logic expClk(input int ph, input int d);
        return ph < d / 2;
    endfunction

    task automatic test_reset();
        rst = 1'b0; div_wr = 1'b0; div_ch = '0; div_val = '0; ch_en = '0; sync_all = 1'b0;
        step(3);
        nVec++; if (locked !== 1'b0) begin nErr++; $display("[TB] FAIL reset_locked got %b exp 0", locked); end
        nVec++; if (tick !== 3'b000) begin nErr++; $display("[TB] FAIL reset_tick got %b exp 000", tick); end
        nVec++; if (clk_div !== 3'b000) begin nErr++; $display("[TB] FAIL reset_clkdiv got %b exp 000", clk_div); end
        // Channels requested on during lock must stay silent.
        rst = 1'b1; ch_en = 3'b111;
        for (int i = 1; i <= LOCK; i++) begin
            step(1);
            nVec++; if (locked !== (i == LOCK)) begin nErr++; $display("[TB] FAIL lock_wait i=%0d got %b exp %b", i, locked, (i == LOCK)); end
            nVec++; if ({tick, clk_div} !== 6'b0) begin nErr++; $display("[TB] FAIL lock_quiet i=%0d got %b/%b exp 000/000", i, tick, clk_div); end
        end
        ch_en = 3'b000;
        step(1);
    endtask

    task automatic test_div100();
        logic [2:0] eT, eC;
        ch_en = 3'b001;
        step(1);
        for (int j = 0; j < 200; j++) begin
            eT = {2'b00, expTick(j % 100, 100)};
            eC = {2'b00, expClk(j % 100, 100)};
            nVec++; if ({tick, clk_div} !== {eT, eC}) begin nErr++; $display("[TB] FAIL div100 j=%0d got %b/%b exp %b/%b", j, tick, clk_div, eT, eC); end
            step(1);
        end
        ch_en = 3'b000;
        step(1);
        nVec++; if ({tick, clk_div} !== 6'b0) begin nErr++; $display("[TB] FAIL disable got %b/%b exp 000/000", tick, clk_div); end
    endtask

    task automatic test_div_change();
        logic [2:0] eT, eC;
        int ph, d;
        div_wr = 1'b1; div_ch = 2'd1; div_val = 16'd5;
        step(1);
        div_wr = 1'b0; ch_en = 3'b010;
        step(1);
        for (int j = 0; j <= 20; j++) begin
            if (j < 5) begin ph = j; d = 5; end
            else begin ph = (j - 5) % 8; d = 8; end
            eT = {1'b0, expTick(ph, d), 1'b0};
            eC = {1'b0, expClk(ph, d), 1'b0};
            nVec++; if ({tick, clk_div} !== {eT, eC}) begin nErr++; $display("[TB] FAIL div_change j=%0d got %b/%b exp %b/%b", j, tick, clk_div, eT, eC); end
            if (j == 2) begin div_wr = 1'b1; div_ch = 2'd1; div_val = 16'd8; end
            else div_wr = 1'b0;
            step(1);
        end
        ch_en = 3'b000;
        step(1);
    endtask

    task automatic test_clamp_range();
        logic [2:0] eT, eC;
        div_wr = 1'b1; div_ch = 2'd2; div_val = 16'd0;
        step(1);
        div_ch = 2'd3; div_val = 16'd9;
        step(1);
        div_wr = 1'b0; ch_en = 3'b111;
        step(1);
        for (int j = 0; j <= 101; j++) begin
            eT = {expTick(j % 2, 2), expTick(j % 8, 8), expTick(j % 100, 100)};
            eC = {expClk(j % 2, 2), expClk(j % 8, 8), expClk(j % 100, 100)};
            nVec++; if ({tick, clk_div} !== {eT, eC}) begin nErr++; $display("[TB] FAIL clamp_range j=%0d got %b/%b exp %b/%b", j, tick, clk_div, eT, eC); end
            step(1);
        end
        ch_en = 3'b000;
        step(1);
    endtask

    task automatic test_sync();
        logic [2:0] eT, eC;
        div_wr = 1'b1; div_ch = 2'd0; div_val = 16'd10;
        step(1);
        div_ch = 2'd1; div_val = 16'd7;
        step(1);
        div_wr = 1'b0; ch_en = 3'b001;
        step(4);
        ch_en = 3'b011;
        step(3);
        // ch0 in phase 6 of 10, ch1 in phase 2 of 7
        nVec++; if ({tick, clk_div} !== 6'b000_010) begin nErr++; $display("[TB] FAIL pre_sync got %b/%b exp 000/010", tick, clk_div); end
        sync_all = 1'b1;
        step(1);
        sync_all = 1'b0;
        for (int j = 0; j < 30; j++) begin
            eT = {1'b0, expTick(j % 7, 7), expTick(j % 10, 10)};
            eC = {1'b0, expClk(j % 7, 7), expClk(j % 10, 10)};
            nVec++; if ({tick, clk_div} !== {eT, eC}) begin nErr++; $display("[TB] FAIL sync j=%0d got %b/%b exp %b/%b", j, tick, clk_div, eT, eC); end
            if (j < 29) step(1);
        end
        // ch0 is now in its tick phase; resync with a simultaneous divisor write.
        sync_all = 1'b1; div_wr = 1'b1; div_ch = 2'd0; div_val = 16'd6;
        step(1);
        sync_all = 1'b0; div_wr = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            eT = {1'b0, expTick(k % 7, 7), expTick(k % 6, 6)};
            eC = {1'b0, expClk(k % 7, 7), expClk(k % 6, 6)};
            nVec++; if ({tick, clk_div} !== {eT, eC}) begin nErr++; $display("[TB] FAIL sync_write k=%0d got %b/%b exp %b/%b", k, tick, clk_div, eT, eC); end
            if (k < 12) step(1);
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] eT, eC;
        div_wr = 1'b1; div_ch = 2'd0; div_val = 16'd12;
        step(1);
        div_wr = 1'b0; rst = 1'b0;
        step(1);
        nVec++; if ({tick, clk_div, locked} !== 7'b0) begin nErr++; $display("[TB] FAIL mid_reset got %b/%b/%b exp 000/000/0", tick, clk_div, locked); end
        rst = 1'b1;
        for (int i = 1; i <= LOCK; i++) begin
            step(1);
            nVec++; if (locked !== (i == LOCK)) begin nErr++; $display("[TB] FAIL relock i=%0d got %b exp %b", i, locked, (i == LOCK)); end
            nVec++; if ({tick, clk_div} !== 6'b0) begin nErr++; $display("[TB] FAIL relock_quiet i=%0d got %b/%b exp 000/000", i, tick, clk_div); end
        end
        step(1);
        for (int j = 0; j <= 100; j++) begin
            eT = {1'b0, expTick(j % 100, 100), expTick(j % 100, 100)};
            eC = {1'b0, expClk(j % 100, 100), expClk(j % 100, 100)};
            nVec++; if ({tick, clk_div} !== {eT, eC}) begin nErr++; $display("[TB] FAIL post_reset j=%0d got %b/%b exp %b/%b", j, tick, clk_div, eT, eC); end
            step(1);
        end
    endtask

    initial begin
        test_reset();
        test_div100();
        test_div_change();
        test_clamp_range();
        test_sync();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
